// File: rtl/add_arbiter.sv
// Purpose : round-robin share of one external WIDTH-bit adder among NREQ requesters.
// Latency : handshake edge -> rsp_valid two edges later; at most one result every 2 cycles.
// Backpr. : rsp_ready low holds the result in place and blocks all new grants.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/ready           per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_cin       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub                   per-requester subtract select (only with ADD_ARB_SUB_EN)
//   add_a/add_b/add_cin       registered operands to the shared adder
//   add_sum/add_cout          combinational result from the shared adder
//   rsp_valid/ready           response handshake
//   rsp_sum/rsp_cout/rsp_id   registered result, carry-out and owning requester
//
// Optional feature: define ADD_ARB_SUB_EN to add req_sub; a granted requester with
// req_sub set gets a - b (b inverted, carry-in forced to 1).
module add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
`ifdef ADD_ARB_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   tag;
  logic             any_vld;
  logic             can_accept;
  logic             grant_en;
  logic             hs;
  logic             post_rst;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;
  int               best_dist;
  int               cand_dist;

  // Round-robin pick: among valid requesters, the one at the smallest
  // forward distance from ptr (ptr itself is distance 0).
  always_comb begin
    gnt       = '0;
    best_dist = NREQ;
    cand_dist = 0;
    any_vld   = |req_valid;
    for (int i = 0; i < NREQ; i++) begin
      cand_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
      if (req_valid[i] && (cand_dist < best_dist)) begin
        best_dist = cand_dist;
        gnt       = IDW'(i);
      end
    end
  end

  // Operands of the selected requester, with the optional subtract rewrite.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
`ifdef ADD_ARB_SUB_EN
        if (req_sub[i]) begin
          sel_b   = ~req_b[i*WIDTH +: WIDTH];
          sel_cin = 1'b1;
        end
`endif
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = hs ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Grants are suppressed while rst is high and for one cycle after it.
  always_comb begin
    can_accept = (state == IDLE) || ((state == HOLD) && rsp_ready);
    grant_en   = can_accept && any_vld && !post_rst && !rst;
    rsp_valid  = (state == HOLD);
    req_ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_en && (gnt == IDW'(i));
    end
  end

  assign hs = |(req_valid & req_ready);

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      post_rst <= 1'b1;
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      tag      <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      post_rst <= 1'b0;
      if (hs) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_cin <= sel_cin;
        tag    <= gnt;
        ptr    <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
      end
      // The adder settles during ISSUE; capture its result at the end of it.
      if (state == ISSUE) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_id   <= tag;
      end
    end
  end

  // Operand registers are never cleared after use, keeping the adder inputs quiet.
  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_cin;

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_cin;
`ifdef ADD_ARB_SUB_EN
  logic [NREQ-1:0]       req_sub;
`endif
  logic [WIDTH-1:0]      add_a, add_b, add_sum;
  logic                  add_cin, add_cout;
  logic                  rsp_valid, rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Shared adder stand-in (purely combinational).
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef ADD_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    int          id;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        cout;
    int          gcyc;
  } exp_t;

  // Per-requester copy of the currently driven operands.
  logic [63:0] ra [NREQ];
  logic [63:0] rb [NREQ];
  logic        rc [NREQ];
  logic        rs [NREQ];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i] = cin;
    ra[i] = a; rb[i] = b; rc[i] = cin; rs[i] = sub;
`ifdef ADD_ARB_SUB_EN
    req_sub[i] = sub;
`endif
  endtask

  // Reference arithmetic: a + b + cin, or a - b when subtraction is selected.
  function automatic logic [64:0] model_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
    logic [63:0] bb;
    logic        c;
    bb = b;
    c  = cin;
`ifdef ADD_ARB_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`else
    if (sub) c = cin;
`endif
    return {1'b0, a} + {1'b0, bb} + {64'd0, c};
  endfunction

  // First valid requester at or after p, wrapping.
  function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (((v >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[$];
  exp_t q[$];

  initial begin
    int          mptr;
    bit          blocked;
    logic [64:0] r;

    rst = 1'b1;
    req_valid = '1;
    req_a = '0; req_b = '0; req_cin = '0;
`ifdef ADD_ARB_SUB_EN
    req_sub = '0;
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'(i) * 64'h100, 64'(i), 1'b0, 1'b0);

    // ---------------- reset state ----------------
    step();
    step();
    settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    rst = 1'b0;
    settle();
    chk("post_rst_ready", req_ready, 0);
    step();
    settle();

    // ---------------- round robin, all requesters valid ----------------
    for (int n = 0; n < 8; n++) begin
      chk("rr_grant", req_ready, 64'(1) << (n % NREQ));
      step(); settle();
      chk("rr_issue_ready", req_ready, 0);
      chk("rr_issue_valid", rsp_valid, 0);
      step(); settle();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, 64'(n % NREQ));
      chk("rr_rsp_sum", rsp_sum, 64'((n % NREQ) * 257));
    end
    req_valid = '0;
    step(); settle();

    // ---------------- backpressure ----------------
    set_req(1, 64'h10, 64'h20, 1'b0, 1'b0);
    set_req(2, 64'h3, 64'h4, 1'b1, 1'b0);
    req_valid = 4'b0010;
    settle();
    chk("bp_grant1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    settle();
    chk("bp_issue_ready", req_ready, 0);
    step();
    for (int n = 0; n < 5; n++) begin
      settle();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_hold_sum", rsp_sum, 64'h30);
      chk("bp_hold_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_release_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    settle();
    chk("bp_gap_valid", rsp_valid, 0);
    step(); settle();
    chk("bp_next_valid", rsp_valid, 1);
    chk("bp_next_id", rsp_id, 2);
    chk("bp_next_sum", rsp_sum, 64'h8);
    step(); settle();

    // ---------------- reset during ISSUE ----------------
    set_req(2, 64'h55, 64'h11, 1'b0, 1'b0);
    req_valid = 4'b0100;
    settle();
    chk("ri_grant", req_ready, 4'b0100);
    step();
    rst = 1'b1;
    req_valid = 4'b1100;
    settle();
    chk("ri_ready_in_rst", req_ready, 0);
    step();
    rst = 1'b0;
    set_req(2, 64'h20, 64'h22, 1'b0, 1'b0);
    settle();
    chk("ri_rsp_valid_after", rsp_valid, 0);
    chk("ri_ready_after", req_ready, 0);
    step(); settle();
    chk("ri_no_stale_rsp", rsp_valid, 0);
    chk("ri_ptr_reset_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step(); settle();
    chk("ri_rsp_valid", rsp_valid, 1);
    chk("ri_rsp_id", rsp_id, 2);
    chk("ri_rsp_sum", rsp_sum, 64'h42);
    step(); settle();

    // ---------------- table-driven single transactions ----------------
    vt.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 64'h0, 1'b1});
    vt.push_back('{64'h7, 64'h8, 1'b1, 1'b0, 3, 64'h10, 1'b0});
    vt.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1, 64'h1, 1'b1});
    vt.push_back('{64'h1234_5678, 64'h1, 1'b0, 1'b0, 2, 64'h1234_5679, 1'b0});
    vt.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1, 64'h0, 1'b1});
    vt.push_back('{64'h0, 64'h0, 1'b0, 1'b0, 0, 64'h0, 1'b0});
`ifdef ADD_ARB_SUB_EN
    vt.push_back('{64'h5, 64'h7, 1'b0, 1'b1, 2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vt.push_back('{64'h7, 64'h5, 1'b0, 1'b1, 0, 64'h2, 1'b1});
    vt.push_back('{64'h7, 64'h5, 1'b1, 1'b1, 1, 64'h2, 1'b1});
    vt.push_back('{64'h5, 64'h7, 1'b1, 1'b0, 3, 64'hD, 1'b0});
`endif
    foreach (vt[k]) begin
      set_req(vt[k].id, vt[k].a, vt[k].b, vt[k].cin, vt[k].sub);
      req_valid = 4'(1 << vt[k].id);
      settle();
      chk("vec_grant", req_ready, 64'(1) << vt[k].id);
      step();
      req_valid = '0;
      step(); settle();
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_sum", rsp_sum, vt[k].sum);
      chk("vec_rsp_cout", rsp_cout, vt[k].cout);
      chk("vec_rsp_id", rsp_id, 64'(vt[k].id));
      step(); settle();
    end

    // ---------------- randomized run against the reference model ----------------
    rst = 1'b1;
    step();
    q.delete();
    mptr = 0;
    blocked = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [NREQ-1:0] v;
      logic [NREQ-1:0] exp_r;
      bit              do_rst, consume, allow, exp_v;
      int              g;
      exp_t            e;

      do_rst = ($urandom_range(0, 99) == 0);
      rst = do_rst;
      v = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) v = '0;
      req_valid = v;
      for (int i = 0; i < NREQ; i++) begin
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) a = '1;
        if ($urandom_range(0, 7) == 0) b = 64'h1;
        set_req(i, a, b, 1'($urandom), 1'($urandom));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle();

      if (do_rst) begin
        chk("rnd_ready_in_rst", req_ready, 0);
      end else begin
        consume = rsp_valid && rsp_ready;
        exp_v = (q.size() > 0) && (cyc >= q[0].gcyc + 2);
        chk("rnd_rsp_valid", rsp_valid, exp_v);
        if (rsp_valid && exp_v) begin
          chk("rnd_rsp_id", rsp_id, 64'(q[0].id));
          chk("rnd_rsp_sum", rsp_sum, q[0].sum);
          chk("rnd_rsp_cout", rsp_cout, q[0].cout);
        end
        allow = !blocked && (v != '0) &&
                ((q.size() == 0) || ((q.size() == 1) && consume));
        g = rr_pick(mptr, v);
        exp_r = allow ? NREQ'(1 << g) : '0;
        chk("rnd_req_ready", req_ready, exp_r);
        if (consume && q.size() > 0) void'(q.pop_front());
        if (allow) begin
          r = model_add(ra[g], rb[g], rc[g], rs[g]);
          e.id   = g;
          e.sum  = r[63:0];
          e.cout = r[64];
          e.gcyc = cyc;
          q.push_back(e);
          mptr = (g + 1) % NREQ;
        end
      end
      step();
      if (do_rst) begin
        q.delete();
        mptr = 0;
        blocked = 1'b1;
      end else begin
        blocked = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
